mac_norm_stage: RTL and testbench



---
 rtl/mac_package.sv | 41 ++++
 rtl/mac_norm_stage_if.sv | 41 ++++
 rtl/mac_norm_stage_datapath.sv | 65 ++++++
 rtl/mac_norm_stage.sv | 198 +++++++++++++++++++
 tb/tb_mac_norm_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_package.sv
`default_nettype none
// ============================================================================
//  Module      : mac_package
//  Description : Shared types and constants for the MAC output normalization
//                stage: controller-side config/flag bundles and the stage
//                FSM state encoding.
//  Contents    : ctrl_norm_t, flags_norm_t, norm_state_t, MAC_NORM_* widths
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_package;

  localparam int MAC_NORM_SAT_CNT_W = 16;
  localparam int MAC_NORM_SHIFT_W   = 6;
  localparam int MAC_NORM_CNT_W     = 16;

  typedef enum logic [1:0] {
    NORM_IDLE  = 2'd0,
    NORM_RUN   = 2'd1,
    NORM_DRAIN = 2'd2,
    NORM_DONE  = 2'd3
  } norm_state_t;

  // Per-job configuration as driven by the controller's ctrl_engine fields
  typedef struct packed {
    logic                        start;
    logic [MAC_NORM_SHIFT_W-1:0] shift;
    logic                        round_en;
    logic                        sat_en;
    logic [MAC_NORM_CNT_W-1:0]   len;
  } ctrl_norm_t;

  // Status reported back to the controller
  typedef struct packed {
    logic                          busy;
    logic                          done;
    logic [MAC_NORM_CNT_W-1:0]     cnt;
    logic [MAC_NORM_SAT_CNT_W-1:0] sat_cnt;
  } flags_norm_t;

endpackage
`default_nettype wire

// File: rtl/mac_norm_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_norm_stage_if
//  Description : Stream bundle of the normalization stage: accumulator input
//                stream and normalized output stream (valid/ready/data).
//  Modports    : slave  - the normalization stage (consumes acc, produces out)
//                master - the surrounding engine/sink side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_norm_stage_if #(
  parameter int ACC_WIDTH = 64,
  parameter int OUT_WIDTH = 32
);

  logic                 acc_valid_i;
  logic                 acc_ready_o;
  logic [ACC_WIDTH-1:0] acc_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [OUT_WIDTH-1:0] out_data_o;

  modport slave (
    input  acc_valid_i,
    input  acc_data_i,
    input  out_ready_i,
    output acc_ready_o,
    output out_valid_o,
    output out_data_o
  );

  modport master (
    output acc_valid_i,
    output acc_data_i,
    output out_ready_i,
    input  acc_ready_o,
    input  out_valid_o,
    input  out_data_o
  );

endinterface
`default_nettype wire

// File: rtl/mac_norm_stage_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mac_norm_datapath
//  Description : Combinational arithmetic of the normalization stage.
//                Front half (feeds S1): sign-extend, optional half-LSB bias,
//                arithmetic right shift, all in ACC_WIDTH+1 bits.
//                Back half (feeds S2): saturate or truncate to OUT_WIDTH.
//  Ports       : acc/shift/round_en -> shifted      (S1 input)
//                s1_data/sat_en     -> norm_data, sat (S2 input)
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_norm_datapath
  import mac_package::*;
#(
  parameter int ACC_WIDTH   = 64,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   round_en,
  output logic [ACC_WIDTH:0]     shifted,
  input  logic [ACC_WIDTH:0]     s1_data,
  input  logic                   sat_en,
  output logic [OUT_WIDTH-1:0]   norm_data,
  output logic                   sat
);

  logic signed [ACC_WIDTH:0] w_ext;
  logic signed [ACC_WIDTH:0] w_bias;
  logic signed [ACC_WIDTH:0] w_sum;
  logic                      w_pos_ovf;
  logic                      w_neg_ovf;

  // The extra headroom bit keeps the rounding bias from overflowing.
  always_comb begin
    w_ext  = {acc[ACC_WIDTH-1], acc};
    w_bias = '0;
    if (round_en && (shift != '0)) begin
      w_bias[shift - 1'b1] = 1'b1;
    end
    w_sum   = w_ext + w_bias;
    shifted = w_sum >>> shift;
  end

  // Value fits in OUT_WIDTH iff every bit from the top down to OUT_WIDTH-1
  // equals the sign bit.
  always_comb begin
    w_pos_ovf = ~s1_data[ACC_WIDTH] &  (|s1_data[ACC_WIDTH-1:OUT_WIDTH-1]);
    w_neg_ovf =  s1_data[ACC_WIDTH] & ~(&s1_data[ACC_WIDTH-1:OUT_WIDTH-1]);
    norm_data = s1_data[OUT_WIDTH-1:0];
    sat       = 1'b0;
    if (sat_en) begin
      if (w_pos_ovf) begin
        norm_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        sat       = 1'b1;
      end else if (w_neg_ovf) begin
        norm_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        sat       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_norm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mac_norm_stage
//  Description : Output normalization stage between the MAC accumulator
//                stream and the d-sink streamer. Two-stage pipeline
//                (S1 round+shift, S2 saturate/truncate), job control FSM,
//                output and saturation-event counters.
//  Ports       : clk_i, rst_i (async, active high), clear_i (sync soft clear)
//                start_i, shift_i, round_en_i, sat_en_i, len_i - job config
//                bus (slave) - acc_valid/ready/data in, out_valid/ready/data
//                busy_o, done_o, cnt_o, sat_cnt_o - job status
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_norm_stage
  import mac_package::*;
#(
  parameter int ACC_WIDTH   = 64,
  parameter int OUT_WIDTH   = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic                          round_en_i,
  input  logic                          sat_en_i,
  input  logic [CNT_WIDTH-1:0]          len_i,
  mac_norm_stage_if.slave               bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CNT_WIDTH-1:0]          cnt_o,
  output logic [MAC_NORM_SAT_CNT_W-1:0] sat_cnt_o
);

  // Encodings track norm_state_t
  localparam logic [1:0] c_st_idle  = NORM_IDLE;
  localparam logic [1:0] c_st_run   = NORM_RUN;
  localparam logic [1:0] c_st_drain = NORM_DRAIN;
  localparam logic [1:0] c_st_done  = NORM_DONE;

  logic [1:0]                    r_state;
  logic [SHIFT_WIDTH-1:0]        r_shift;
  logic                          r_round;
  logic                          r_sat;
  logic [CNT_WIDTH-1:0]          r_len;
  logic [CNT_WIDTH-1:0]          r_acc_cnt;
  logic [CNT_WIDTH-1:0]          r_cnt;
  logic [MAC_NORM_SAT_CNT_W-1:0] r_sat_cnt;

  logic                          r_s1_valid;
  logic [ACC_WIDTH:0]            r_s1_data;
  logic                          r_s2_valid;
  logic [OUT_WIDTH-1:0]          r_s2_data;
  logic                          r_s2_sat;

  logic                          w_s2_free;
  logic                          w_s1_adv;
  logic                          w_acc_ready;
  logic                          w_acc_fire;
  logic                          w_out_fire;
  logic [CNT_WIDTH-1:0]          w_acc_cnt_nxt;
  logic [ACC_WIDTH:0]            w_shifted;
  logic [OUT_WIDTH-1:0]          w_norm;
  logic                          w_sat;

  // Each stage may load when it is empty or its content moves on this cycle,
  // which gives full throughput and no bubble when backpressure releases.
  assign w_s2_free     = ~r_s2_valid | bus.out_ready_i;
  assign w_s1_adv      = r_s1_valid & w_s2_free;
  assign w_acc_ready   = (r_state == c_st_run) & (~r_s1_valid | w_s2_free);
  assign w_acc_fire    = w_acc_ready & bus.acc_valid_i;
  assign w_out_fire    = r_s2_valid & bus.out_ready_i;
  assign w_acc_cnt_nxt = r_acc_cnt + 1'b1;

  mac_norm_datapath #(
    .ACC_WIDTH   (ACC_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_datapath (
    .acc       (bus.acc_data_i),
    .shift     (r_shift),
    .round_en  (r_round),
    .shifted   (w_shifted),
    .s1_data   (r_s1_data),
    .sat_en    (r_sat),
    .norm_data (w_norm),
    .sat       (w_sat)
  );

  // Job control, latched configuration and counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= c_st_idle;
      r_shift   <= '0;
      r_round   <= 1'b0;
      r_sat     <= 1'b0;
      r_len     <= '0;
      r_acc_cnt <= '0;
      r_cnt     <= '0;
      r_sat_cnt <= '0;
    end else if (clear_i) begin
      r_state   <= c_st_idle;
      r_shift   <= '0;
      r_round   <= 1'b0;
      r_sat     <= 1'b0;
      r_len     <= '0;
      r_acc_cnt <= '0;
      r_cnt     <= '0;
      r_sat_cnt <= '0;
    end else begin
      if (w_acc_fire) begin
        r_acc_cnt <= w_acc_cnt_nxt;
      end
      if (w_out_fire) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_out_fire && r_s2_sat && (r_sat_cnt != '1)) begin
        r_sat_cnt <= r_sat_cnt + 1'b1;
      end

      case (r_state)
        c_st_idle: begin
          if (start_i) begin
            r_shift   <= shift_i;
            r_round   <= round_en_i;
            r_sat     <= sat_en_i;
            r_len     <= len_i;
            r_acc_cnt <= '0;
            r_cnt     <= '0;
            r_sat_cnt <= '0;
            r_state   <= (len_i == '0) ? c_st_done : c_st_run;
          end
        end
        c_st_run: begin
          if (w_acc_fire && (w_acc_cnt_nxt == r_len)) begin
            r_state <= c_st_drain;
          end
        end
        c_st_drain: begin
          if (!r_s1_valid && !r_s2_valid && (r_cnt == r_len)) begin
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Pipeline registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= 1'b0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= 1'b0;
    end else begin
      if (w_acc_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= w_shifted;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Data is held while stalled so the sink sees a stable word.
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_norm;
          r_s2_sat  <= w_sat;
        end
      end
    end
  end

  assign bus.acc_ready_o = w_acc_ready;
  assign bus.out_valid_o = r_s2_valid;
  assign bus.out_data_o  = r_s2_data;
  assign busy_o          = (r_state != c_st_idle);
  assign done_o          = (r_state == c_st_done);
  assign cnt_o           = r_cnt;
  assign sat_cnt_o       = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_norm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_norm_stage
//  Description : Directed self-checking bench for mac_norm_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_norm_stage;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        start;
  logic [5:0]  shift;
  logic        round_en;
  logic        sat_en;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [15:0] cnt;
  logic [15:0] sat_cnt;

  mac_norm_stage_if #(.ACC_WIDTH(64), .OUT_WIDTH(32)) bus_if ();

  mac_norm_stage dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .start_i    (start),
    .shift_i    (shift),
    .round_en_i (round_en),
    .sat_en_i   (sat_en),
    .len_i      (len),
    .bus        (bus_if.slave),
    .busy_o     (busy),
    .done_o     (done),
    .cnt_o      (cnt),
    .sat_cnt_o  (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] vin  [16];
  logic [31:0] vexp [16];
  logic [31:0] got [$];
  int          in_cyc [$];
  int          out_cyc [$];
  int          done_cnt;
  int          done_cyc;
  int          dcount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string name, input int n);
    chk({name, "_count"}, got.size(), n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_out%0d", name, k), (k < got.size()) ? got[k] : 32'hx, vexp[k]);
    end
  endtask

  // One job: start pulse, then per-cycle drive at negedge, sample 1 ns later.
  task automatic run_job(input int n_in, input logic [15:0] jlen, input logic [5:0] jshift,
                         input logic jround, input logic jsat, input bit stall,
                         input int glitch_cyc, input int clear_after);
    int          idx;
    int          inflight;
    bit          prev_stall;
    logic [31:0] prev_data;
    got.delete(); in_cyc.delete(); out_cyc.delete();
    done_cnt = 0; done_cyc = -1; idx = 0; prev_stall = 0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; len = jlen; shift = jshift; round_en = jround; sat_en = jsat;
    @(negedge clk);
    start = 1'b0; len = 16'd1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (clear_after >= 0 && got.size() >= clear_after) begin
        bus_if.acc_valid_i = 1'b0;
        bus_if.out_ready_i = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        return;
      end
      bus_if.acc_valid_i = (idx < n_in);
      bus_if.acc_data_i  = (idx < 16) ? vin[idx] : 64'h0;
      bus_if.out_ready_i = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start = (cyc == glitch_cyc);
      #1;
      if (prev_stall) begin
        chk("stall_valid_held", bus_if.out_valid_o, 1'b1);
        chk("stall_data_held", bus_if.out_data_o, prev_data);
      end
      inflight = idx - got.size();
      if (inflight == 2 && !bus_if.out_ready_i)
        chk("full_stall_acc_ready", bus_if.acc_ready_o, 1'b0);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus_if.acc_valid_i && bus_if.acc_ready_o) begin
        in_cyc.push_back(cyc);
        idx++;
      end
      if (bus_if.out_valid_o && bus_if.out_ready_i) begin
        got.push_back(bus_if.out_data_o);
        out_cyc.push_back(cyc);
      end
      prev_stall = bus_if.out_valid_o && !bus_if.out_ready_i;
      prev_data  = bus_if.out_data_o;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    bus_if.acc_valid_i = 1'b0;
    bus_if.out_ready_i = 1'b1;
    chk("job_done_seen", (done_cyc >= 0), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; shift = '0; round_en = 1'b0;
    sat_en = 1'b0; len = '0;
    bus_if.acc_valid_i = 1'b0; bus_if.acc_data_i = '0; bus_if.out_ready_i = 1'b1;

    // ---- reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_acc_ready", bus_if.acc_ready_o, 1'b0);
    chk("rst_out_valid", bus_if.out_valid_o, 1'b0);
    chk("rst_out_data", bus_if.out_data_o, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", cnt, 16'h0);
    chk("rst_sat_cnt", sat_cnt, 16'h0);

    // ---- A: pass-through, latency 2, ignored start at cycle 1
    vin[0] = 64'h1; vin[1] = 64'hFFFF_FFFF_FFFF_FFFF; vin[2] = 64'h5; vin[3] = 64'h7FFF_FFFF;
    vexp[0] = 32'h1; vexp[1] = 32'hFFFF_FFFF; vexp[2] = 32'h5; vexp[3] = 32'h7FFF_FFFF;
    run_job(4, 16'd4, 6'd0, 1'b0, 1'b1, 1'b0, 1, -1);
    check_outputs("A", 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("A_latency%0d", k), out_cyc[k] - in_cyc[k], 2);
    chk("A_done_pulses", done_cnt, 1);
    chk("A_done_after_last", (done_cyc > out_cyc[3]), 1'b1);
    chk("A_cnt", cnt, 16'd4);
    chk("A_sat_cnt", sat_cnt, 16'd0);
    chk("A_busy_end", busy, 1'b0);

    // ---- B/C: rounding
    vin[0] = 64'h18; vin[1] = 64'hFFFF_FFFF_FFFF_FFE8;
    vexp[0] = 32'h2; vexp[1] = 32'hFFFF_FFFF;
    run_job(2, 16'd2, 6'd4, 1'b1, 1'b1, 1'b0, -1, -1);
    check_outputs("B_round", 2);
    vexp[0] = 32'h1; vexp[1] = 32'hFFFF_FFFE;
    run_job(2, 16'd2, 6'd4, 1'b0, 1'b1, 1'b0, -1, -1);
    check_outputs("C_trunc", 2);

    // ---- D/E: saturation vs. wrap
    vin[0] = 64'h1_0000_0000; vin[1] = 64'hFFFF_FFFE_FFFF_FFFF;
    vexp[0] = 32'h7FFF_FFFF; vexp[1] = 32'h8000_0000;
    run_job(2, 16'd2, 6'd0, 1'b0, 1'b1, 1'b0, -1, -1);
    check_outputs("D_sat", 2);
    chk("D_sat_cnt", sat_cnt, 16'd2);
    vexp[0] = 32'h0; vexp[1] = 32'hFFFF_FFFF;
    run_job(2, 16'd2, 6'd0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_outputs("E_wrap", 2);
    chk("E_sat_cnt", sat_cnt, 16'd0);

    // ---- F: backpressure 1,0,0,1 with shift 1 + rounding
    vin[0] = 64'd3; vin[1] = 64'd4; vin[2] = 64'hFFFF_FFFF_FFFF_FFFD; vin[3] = 64'd100;
    vin[4] = 64'hFFFF_FFFF_FFFF_FF9C; vin[5] = 64'd7; vin[6] = 64'd0;
    vin[7] = 64'hFFFF_FFFF_FFFF_FFFF;
    vexp[0] = 32'h2; vexp[1] = 32'h2; vexp[2] = 32'hFFFF_FFFF; vexp[3] = 32'h32;
    vexp[4] = 32'hFFFF_FFCE; vexp[5] = 32'h4; vexp[6] = 32'h0; vexp[7] = 32'h0;
    run_job(8, 16'd8, 6'd1, 1'b1, 1'b1, 1'b1, -1, -1);
    check_outputs("F_stall", 8);
    chk("F_cnt", cnt, 16'd8);
    chk("F_done_pulses", done_cnt, 1);

    // ---- G: zero-length job
    run_job(0, 16'd0, 6'd0, 1'b0, 1'b0, 1'b0, -1, -1);
    chk("G_done_cycle", done_cyc, 0);
    chk("G_no_outputs", got.size(), 0);
    chk("G_done_pulses", done_cnt, 1);

    // ---- H: soft clear after 3 of 6 results
    for (int k = 0; k < 6; k++) vin[k] = 64'(k + 1);
    run_job(6, 16'd6, 6'd0, 1'b0, 1'b1, 1'b0, -1, 3);
    #1;
    chk("H_outputs_before_clear", got.size(), 3);
    chk("H_busy", busy, 1'b0);
    chk("H_out_valid", bus_if.out_valid_o, 1'b0);
    chk("H_cnt", cnt, 16'd0);
    chk("H_done", done, 1'b0);
    chk("H_acc_ready", bus_if.acc_ready_o, 1'b0);
    dcount = 0;
    bus_if.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (done) dcount++;
    end
    chk("H_no_done_after_clear", dcount, 0);

    // ---- I: asynchronous reset mid-job
    @(negedge clk);
    start = 1'b1; len = 16'd4; shift = 6'd0; round_en = 1'b0; sat_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_if.acc_valid_i = 1'b1; bus_if.acc_data_i = 64'h55; bus_if.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("I_pre_out_valid", bus_if.out_valid_o, 1'b1);
    chk("I_pre_out_data", bus_if.out_data_o, 32'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("I_rst_out_valid", bus_if.out_valid_o, 1'b0);
    chk("I_rst_out_data", bus_if.out_data_o, 32'h0);
    chk("I_rst_busy", busy, 1'b0);
    chk("I_rst_acc_ready", bus_if.acc_ready_o, 1'b0);
    chk("I_rst_cnt", cnt, 16'h0);
    chk("I_rst_sat_cnt", sat_cnt, 16'h0);
    bus_if.acc_valid_i = 1'b0; bus_if.out_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("I_post_busy", busy, 1'b0);
    chk("I_post_done", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
